// File: rtl/hazard_detection_unit.sv
// Pipeline hazard controller: load-use stalls, data-memory wait freezes and
// branch flushes (deferred while memory is busy), plus saturating event counters.
module hazard_detection_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read_ID_EXE,
    input  logic [REG_ADDR_W-1:0] regfile_waddr_ID_EXE,
    input  logic [REG_ADDR_W-1:0] instruction_IF_ID_Rs,
    input  logic [REG_ADDR_W-1:0] instruction_IF_ID_Rt,
    input  logic                  uses_rt_IF_ID,
    input  logic                  branch_taken_EXE,
    input  logic                  mem_busy,
    output logic                  pc_write_en,
    output logic                  if_id_write_en,
    output logic                  id_exe_bubble,
    output logic                  pipe_freeze,
    output logic                  if_id_flush,
    output logic                  id_exe_flush,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count,
    output logic [1:0]            state_dbg
);

    localparam logic [1:0] S_RUN        = 2'd0;
    localparam logic [1:0] S_LOAD_STALL = 2'd1;
    localparam logic [1:0] S_MEM_WAIT   = 2'd2;
    localparam logic [1:0] S_FLUSH_PEND = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic             r_branch_pending;
    logic             w_next_pending;
    logic [CNT_W-1:0] r_stall_count;
    logic [CNT_W-1:0] r_flush_count;
    logic             w_hazard;
    logic             w_pc_write_en;
    logic             w_if_id_write_en;
    logic             w_id_exe_bubble;
    logic             w_pipe_freeze;
    logic             w_flush;

    // Writes to $zero never create a real dependency, so they are exempt.
    assign w_hazard = mem_read_ID_EXE
                   && (regfile_waddr_ID_EXE != '0)
                   && ((regfile_waddr_ID_EXE == instruction_IF_ID_Rs)
                       || (uses_rt_IF_ID && (regfile_waddr_ID_EXE == instruction_IF_ID_Rt)));

    // Priority chain: memory wait, then branch flush (owed or current), then load-use.
    always_comb begin
        w_pc_write_en    = 1'b1;
        w_if_id_write_en = 1'b1;
        w_id_exe_bubble  = 1'b0;
        w_pipe_freeze    = 1'b0;
        w_flush          = 1'b0;
        w_next_state     = S_RUN;
        w_next_pending   = r_branch_pending;
        if (rst) begin
            w_next_state   = S_RUN;
            w_next_pending = 1'b0;
        end else if (mem_busy) begin
            w_pipe_freeze    = 1'b1;
            w_pc_write_en    = 1'b0;
            w_if_id_write_en = 1'b0;
            w_next_state     = S_MEM_WAIT;
            if (branch_taken_EXE) begin
                w_next_pending = 1'b1;
            end
        end else if ((r_state == S_FLUSH_PEND) || branch_taken_EXE) begin
            w_flush        = 1'b1;
            w_next_pending = 1'b0;
            w_next_state   = S_RUN;
        end else if ((r_state == S_MEM_WAIT) && r_branch_pending) begin
            w_next_state = S_FLUSH_PEND;
        end else if ((r_state != S_LOAD_STALL) && w_hazard) begin
            w_pc_write_en    = 1'b0;
            w_if_id_write_en = 1'b0;
            w_id_exe_bubble  = 1'b1;
            w_next_state     = S_LOAD_STALL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_RUN;
            r_branch_pending <= 1'b0;
        end else begin
            r_state          <= w_next_state;
            r_branch_pending <= w_next_pending;
        end
    end

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (!w_pc_write_en && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + CNT_ONE;
            end
            if (w_flush && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + CNT_ONE;
            end
        end
    end

    assign pc_write_en    = w_pc_write_en;
    assign if_id_write_en = w_if_id_write_en;
    assign id_exe_bubble  = w_id_exe_bubble;
    assign pipe_freeze    = w_pipe_freeze;
    assign if_id_flush    = w_flush;
    assign id_exe_flush   = w_flush;
    assign stall_count    = r_stall_count;
    assign flush_count    = r_flush_count;
    assign state_dbg      = r_state;

endmodule
